// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-frame shadow snapshot and blanking gap.
// Optional leading-zero blanking on odd (tens) digits: define SEG7_LZB_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   bcd,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_done
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, ON} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           cnt, cnt_next;
  logic [IW-1:0]           idx, idx_next;
  logic                    cnt_last;
  logic                    load_pending;
  logic                    capture;
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [3:0]              digit;
  logic [6:0]              digit_seg;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_next;
  logic                    dp_next;

  assign cnt_last = (cnt == CNT_LAST);
  assign capture  = load_pending | (cnt_last & (idx == IDX_LAST));
  // Gated by reset so the pulse stays low while load_pending sits at its reset value.
  assign frame_done = capture & reset;

  always_comb begin
    cnt_next   = cnt_last ? '0 : cnt + 1'b1;
    idx_next   = idx;
    state_next = state;
    if (cnt_last) idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    if (cnt_next == '0)            state_next = BLANK;
    else if (cnt_next == CNT_BLANK) state_next = ON;
  end

  always_comb begin
    digit = shadow_bcd[4*idx +: 4];
    case (digit)
      4'd0:    digit_seg = 7'b1000000;
      4'd1:    digit_seg = 7'b1111001;
      4'd2:    digit_seg = 7'b0100100;
      4'd3:    digit_seg = 7'b0110000;
      4'd4:    digit_seg = 7'b0011001;
      4'd5:    digit_seg = 7'b0010010;
      4'd6:    digit_seg = 7'b0000010;
      4'd7:    digit_seg = 7'b1111000;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0010000;
      default: digit_seg = 7'b0111111;
    endcase
`ifdef SEG7_LZB_EN
    if (idx[0] && digit == 4'd0) digit_seg = 7'h7F;
`else
`endif
  end

  always_comb begin
    an_next  = '1;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (state == ON) begin
      an_next[idx] = 1'b0;
      seg_next     = digit_seg;
      dp_next      = ~shadow_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BLANK;
      cnt          <= '0;
      idx          <= '0;
      load_pending <= 1'b1;
      shadow_bcd   <= '0;
      shadow_dp    <= '0;
      an           <= '1;
      seg          <= 7'h7F;
      dp           <= 1'b1;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      idx          <= idx_next;
      load_pending <= 1'b0;
      if (capture) begin
        shadow_bcd <= bcd;
        shadow_dp  <= dp_in;
      end
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: small slots, randomized inputs, frame-level reference model.
module tb_seg7_scan_driver;
  localparam int ND = 8;
  localparam int DC = 4;
  localparam int BC = 1;
  localparam int FR = ND * DC;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   bcd = 32'h0;
  logic [7:0]    dp_in = 8'h0;
  logic [7:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_done;

  int checks = 0;
  int errors = 0;
  int p = 0;

  logic [6:0]  seg_tab [16];
  logic [31:0] frame_bcd [256];
  logic [7:0]  frame_dp  [256];
  logic [16:0] exp_pins;

  seg7_scan_driver #(.NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .bcd(bcd), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Called at a negedge: computes expected pins for cycle p (pins show cycle p-1).
  task automatic model_cycle(input bit rnd);
    int q, slot, f;
    logic [3:0] d;
    logic [6:0] s;
    logic       fd;
    #1;
    if (rnd && $urandom_range(7) == 0) begin
      bcd   = $urandom;
      dp_in = 8'($urandom);
    end
    if (p == 0 || p % FR == FR - 1) begin
      frame_bcd[((p + 1) / FR) % 256] = bcd;
      frame_dp[((p + 1) / FR) % 256]  = dp_in;
    end
    fd = (p == 0) || (p % FR == FR - 1);
    q = p - 1;
    if (p == 0 || q % DC < BC) begin
      exp_pins = {8'hFF, 7'h7F, 1'b1, fd};
    end else begin
      slot = (q / DC) % ND;
      f    = (q / FR) % 256;
      d    = frame_bcd[f][4*slot +: 4];
      s    = seg_tab[d];
`ifdef SEG7_LZB_EN
      if (slot % 2 == 1 && d == 4'd0) s = 7'h7F;
`endif
      exp_pins = {~(8'b1 << slot), s, ~frame_dp[f][slot], fd};
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    p++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    p = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bcd   = 32'h76543210;
    dp_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_pins got %h expected %h", {an, seg, dp, frame_done}, {8'hFF, 7'h7F, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_scan_decode();
    release_reset();
    for (int i = 0; i < 2 * FR + 2; i++) begin
      model_cycle(1'b0);
      checks++;
      if ({an, seg, dp, frame_done} !== exp_pins) begin
        errors++;
        $display("FAIL scan_decode p=%0d got %h expected %h", p, {an, seg, dp, frame_done}, exp_pins);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL scan_onehot p=%0d an=%h expected at most one low", p, an);
      end
      next_cycle();
    end
  endtask

  task automatic test_dash();
    bcd = $urandom;
    bcd[3:0] = 4'hB;
    for (int i = 0; i < 2 * FR; i++) begin
      model_cycle(1'b0);
      checks++;
      if ({an, seg, dp, frame_done} !== exp_pins) begin
        errors++;
        $display("FAIL dash p=%0d got %h expected %h", p, {an, seg, dp, frame_done}, exp_pins);
      end
      next_cycle();
    end
  endtask

  task automatic test_tearing();
    bcd = 32'h11111111;
    for (int i = 0; i < 2 * FR + 12; i++) begin
      if (i == FR + 12) bcd = 32'h22222222;
      model_cycle(1'b0);
      checks++;
      if ({an, seg, dp, frame_done} !== exp_pins) begin
        errors++;
        $display("FAIL tearing p=%0d got %h expected %h", p, {an, seg, dp, frame_done}, exp_pins);
      end
      next_cycle();
    end
  endtask

  task automatic test_dp();
    dp_in = 8'b0101_0000;
    for (int i = 0; i < 2 * FR; i++) begin
      model_cycle(1'b0);
      checks++;
      if ({an, seg, dp, frame_done} !== exp_pins) begin
        errors++;
        $display("FAIL decimal_point p=%0d got %h expected %h", p, {an, seg, dp, frame_done}, exp_pins);
      end
      next_cycle();
    end
  endtask

  task automatic test_lzb();
    bcd   = 32'h00000005;
    dp_in = 8'h00;
    for (int i = 0; i < 2 * FR; i++) begin
      model_cycle(1'b0);
      checks++;
      if ({an, seg, dp, frame_done} !== exp_pins) begin
        errors++;
        $display("FAIL lzb p=%0d got %h expected %h", p, {an, seg, dp, frame_done}, exp_pins);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * FR; i++) begin
      model_cycle(1'b1);
      checks++;
      if ({an, seg, dp, frame_done} !== exp_pins) begin
        errors++;
        $display("FAIL random p=%0d got %h expected %h", p, {an, seg, dp, frame_done}, exp_pins);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL random_onehot p=%0d an=%h expected at most one low", p, an);
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    int wait_n;
    wait_n = (14 - (p % FR) + FR) % FR;
    for (int i = 0; i < wait_n; i++) next_cycle();
    #1;
    checks++;
    if (an !== 8'hF7) begin
      errors++;
      $display("FAIL pre_reset_anode got %h expected %h", an, 8'hF7);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got %h expected %h", {an, seg, dp, frame_done}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL async_reset_hold got %h expected %h", {an, seg, dp, frame_done}, {8'hFF, 7'h7F, 1'b1, 1'b0});
      end
    end
    bcd   = $urandom;
    dp_in = 8'($urandom);
    release_reset();
    for (int i = 0; i < FR + 8; i++) begin
      model_cycle(1'b0);
      checks++;
      if ({an, seg, dp, frame_done} !== exp_pins) begin
        errors++;
        $display("FAIL after_reset p=%0d got %h expected %h", p, {an, seg, dp, frame_done}, exp_pins);
      end
      if (i == 2) begin
        checks++;
        if (an !== 8'hFE) begin
          errors++;
          $display("FAIL first_lit_anode got %h expected %h", an, 8'hFE);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
    for (int i = 0; i < 256; i++) begin
      frame_bcd[i] = 32'h0;
      frame_dp[i]  = 8'h0;
    end
    test_reset();
    test_scan_decode();
    test_dash();
    test_tearing();
    test_dp();
    test_lzb();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
